uart_tx_buffer: RTL and testbench
=================================

Name: uart_tx_buffer

Overview:
- Transmit-side byte queue that sits directly upstream of uart_core and drives its data / valid_tx inputs.
- Accepts bytes from a host-side producer through a push interface and stores them in a DEPTH-entry FIFO.
- Hands stored bytes to the UART transmitter one at a time, pacing itself on busy_tx.
- Reports FIFO level, sticky overflow and a start-timeout error.

Parameters:
- DEPTH, 16, FIFO entries; must be a power of 2, ≥2.
- AW, $clog2(DEPTH), pointer width; derived, not overridden.
- TMO_CYC, 1024, cycles to wait for busy_tx rising after a launch before declaring an error; ≥2.

Ports:
- clk  input  1  system clock
- rstn  input  1  asynchronous active-low reset
- wr_data  input  8  byte to enqueue
- wr_en  input  1  push request, sampled on rising clk
- full  output  1  FIFO holds DEPTH entries
- empty  output  1  FIFO holds 0 entries
- en  input  1  launch enable; 0 = hold queue, no new launches
- data  output  8  byte to uart_core (connects to its data input)
- valid_tx  output  1  one-cycle launch strobe to uart_core
- busy_tx  input  1  uart_core transmitter busy
- ovf  output  1  sticky: push attempted while full
- tmo_err  output  1  sticky: busy_tx never rose within TMO_CYC after a launch
- clr_err  input  1  synchronous clear of ovf and tmo_err

Behaviour:
- Reset (async, rstn=0):
  - pointers and count = 0; empty=1, full=0.
  - data=8'h00, valid_tx=0, ovf=0, tmo_err=0, FSM=IDLE, timeout counter=0.
  - Queued bytes are discarded. Reset mid-frame simply abandons the handshake; no replay.
- Count width is AW+1 so that count==DEPTH is representable. full = (count==DEPTH), empty = (count==0); both are registered-equivalent, derived from count.
- Push:
  - Accepted when wr_en & !full; writes mem[wptr], wptr wraps modulo DEPTH.
  - wr_en & full: byte dropped, ovf set next edge.
- Pop: occurs only on the IDLE→LAUNCH transition; rptr advances and wraps modulo DEPTH.
- Simultaneous push and pop: count unchanged. A push accepted when full is impossible; a pop when empty is impossible.
- No bypass: a byte pushed into an empty FIFO at edge k is seen at edge k+1, and valid_tx is high in the cycle after edge k+1.
- FSM:
  - IDLE: if en & !empty & !busy_tx → LAUNCH; data<=mem[rptr]; valid_tx<=1; pop.
  - LAUNCH: valid_tx<=0; timeout counter cleared; → WAIT_START.
  - WAIT_START:
    - busy_tx=1 → WAIT_END.
    - Otherwise count++; when count reaches TMO_CYC-1: tmo_err<=1, → IDLE. The byte is lost, not re-queued.
  - WAIT_END: busy_tx=0 → IDLE.
- Timing guarantees:
  - valid_tx is exactly one cycle wide, with a minimum spacing of 4 cycles between strobes.
  - data holds stable from the valid_tx cycle until the next launch.
- en deasserted mid-transfer: the current byte completes; no further launch until en=1.
- clr_err=1 clears ovf and tmo_err. If a set condition occurs in the same cycle, set wins.

Optional Feature:
- Macro: UART_TX_BUFFER_LEVEL_EN.
- Defined:
  - Adds output port level [AW:0], equal to the current count.
  - Adds output almost_full, asserted when count ≥ DEPTH-2.
  - Reset values: level=0, almost_full=0.
- Undefined: neither port exists; the rest of the behaviour is identical.

Decomposition:
- uart_pkg holds:
  - FSM enum tx_buf_state_e {IDLE, LAUNCH, WAIT_START, WAIT_END}.
  - localparam UART_DW = 8.
  - The existing uart_config structs, untouched.
- One sub-module: uart_sync_fifo (parameters DW, DEPTH) holding storage, pointers, count, full and empty.
- uart_tx_buffer instantiates uart_sync_fifo and adds the FSM, timeout counter and error flags.

Test Plan:
- Reset, en=1, push 8'hA5 at edge 0 with busy_tx=0 → valid_tx=1 for exactly one cycle after edge 1, data=8'hA5, empty=1 after edge 1.
- Push 3 bytes 11/22/33 back-to-back; model busy_tx rising 1 cycle after each valid_tx and falling 20 cycles later → three strobes in order 11, 22, 33; no strobe while busy_tx=1.
- With en=0, push 17 bytes into DEPTH=16 → full=1 after the 16th; the 17th is dropped; ovf=1. clr_err → ovf=0. Releasing en drains exactly 16 bytes with write-order preserved across pointer wrap.
- Launch with busy_tx held 0 → tmo_err=1 after TMO_CYC cycles in WAIT_START; the FSM returns to IDLE and launches the next queued byte.
- Push and launch in the same cycle with count=4 → count stays 4; full and empty unchanged.
- Assert rstn=0 during WAIT_END with 5 bytes queued → immediately empty=1, valid_tx=0, data=00, errors cleared; after release, no strobe until a new push.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types for the UART block: transmit-buffer FSM states,
// data width and the existing line-configuration structure.
package uart_pkg;

  localparam int UART_DW = 8;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_START,
    WAIT_END
  } tx_buf_state_e;

  typedef struct packed {
    logic [15:0] baud_div;
    logic        parity_en;
    logic        parity_odd;
    logic        two_stop;
  } uart_config_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO: storage, wrapping pointers and an occupancy
// count one bit wider than the pointers so a full queue is visible.
module uart_sync_fifo #(
  parameter  int DW    = 8,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          push,
  input  logic [DW-1:0] wdata,
  input  logic          pop,
  output logic [DW-1:0] rdata,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rptr];

  // Storage is not reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  // Pointers wrap naturally at DEPTH; count tracks occupancy.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_buffer.sv
// Byte queue feeding uart_core: launches one byte per handshake.
// Optional level/almost_full ports: define UART_TX_BUFFER_LEVEL_EN.
module uart_tx_buffer
  import uart_pkg::*;
#(
  parameter  int DEPTH   = 16,
  parameter  int TMO_CYC = 1024,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [UART_DW-1:0] wr_data,
  input  logic               wr_en,
  output logic               full,
  output logic               empty,
  input  logic               en,
  output logic [UART_DW-1:0] data,
  output logic               valid_tx,
  input  logic               busy_tx,
  output logic               ovf,
  output logic               tmo_err,
  input  logic               clr_err
`ifdef UART_TX_BUFFER_LEVEL_EN
  ,
  output logic [AW:0]        level,
  output logic               almost_full
`endif
);

  localparam int TW = (TMO_CYC > 2) ? $clog2(TMO_CYC) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYC - 1);

  tx_buf_state_e      state;
  logic [TW-1:0]      tmo_cnt;
  logic [UART_DW-1:0] rdata;
  logic [AW:0]        count;
  logic               pop;
  logic               tmo_hit;

  assign pop = (state == IDLE) & en & ~empty & ~busy_tx;
  assign tmo_hit = (state == WAIT_START) & ~busy_tx
                 & (tmo_cnt == TMO_LAST);

  uart_sync_fifo #(
    .DW    (UART_DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (wr_en),
    .wdata (wr_data),
    .pop   (pop),
    .rdata (rdata),
    .count (count),
    .full  (full),
    .empty (empty)
  );

`ifdef UART_TX_BUFFER_LEVEL_EN
  assign level       = count;
  assign almost_full = (count >= (AW+1)'(DEPTH - 2));
`else
  logic unused_count;
  assign unused_count = ^count;
`endif

  // Launch handshake: strobe, wait for busy to rise, then to fall.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      data     <= '0;
      valid_tx <= 1'b0;
      tmo_cnt  <= '0;
    end else begin
      valid_tx <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pop) begin
            state    <= LAUNCH;
            data     <= rdata;
            valid_tx <= 1'b1;
          end
        end
        LAUNCH: begin
          tmo_cnt <= '0;
          state   <= WAIT_START;
        end
        WAIT_START: begin
          if (busy_tx)      state   <= WAIT_END;
          else if (tmo_hit) state   <= IDLE;
          else              tmo_cnt <= tmo_cnt + 1'b1;
        end
        WAIT_END: begin
          if (!busy_tx) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Sticky error flags; a set in the same cycle beats a clear.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ovf     <= 1'b0;
      tmo_err <= 1'b0;
    end else begin
      if (wr_en & full) ovf <= 1'b1;
      else if (clr_err) ovf <= 1'b0;
      if (tmo_hit)      tmo_err <= 1'b1;
      else if (clr_err) tmo_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Directed bench for uart_tx_buffer with a queue-based reference
// model checked every cycle and a busy_tx responder.
module tb_uart_tx_buffer;

  localparam int DEPTH = 16;
  localparam int TMO   = 32;
  localparam int AW    = $clog2(DEPTH);

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [7:0] wr_data = '0;
  logic       wr_en = 1'b0;
  logic       en = 1'b0;
  logic       busy_tx = 1'b0;
  logic       clr_err = 1'b0;
  logic       full, empty, valid_tx, ovf, tmo_err;
  logic [7:0] data;
`ifdef UART_TX_BUFFER_LEVEL_EN
  logic [AW:0] level;
  logic        almost_full;
`endif

  int errs = 0;
  int checks = 0;

  uart_tx_buffer #(.DEPTH(DEPTH), .TMO_CYC(TMO)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .wr_data  (wr_data),
    .wr_en    (wr_en),
    .full     (full),
    .empty    (empty),
    .en       (en),
    .data     (data),
    .valid_tx (valid_tx),
    .busy_tx  (busy_tx),
    .ovf      (ovf),
    .tmo_err  (tmo_err),
    .clr_err  (clr_err)
`ifdef UART_TX_BUFFER_LEVEL_EN
    ,
    .level       (level),
    .almost_full (almost_full)
`endif
  );

  always #5 clk = ~clk;

  // busy_tx responder: rises one cycle after a strobe, lasts 20 cycles
  bit rsp_on = 1'b0;
  bit rsp_pend = 1'b0;
  int rsp_hold = 0;
  always @(negedge clk) begin
    if (!rsp_on) begin
      busy_tx = 1'b0;
      rsp_hold = 0;
      rsp_pend = 1'b0;
    end else begin
      if (rsp_hold > 0) begin
        rsp_hold--;
        if (rsp_hold == 0) busy_tx = 1'b0;
      end else if (rsp_pend) begin
        busy_tx = 1'b1;
        rsp_hold = 20;
        rsp_pend = 1'b0;
      end
      if (valid_tx) rsp_pend = 1'b1;
    end
  end

  // reference model: a byte queue plus the progress of one transfer
  logic [7:0] mq[$];
  bit         m_busy_xfer;
  int         m_age;
  bit         m_started;
  logic [7:0] m_data;
  bit         m_ovf, m_tmo;
  bit         m_push, m_launch, m_hit, m_oset;
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mq.delete();
      m_busy_xfer = 1'b0;
      m_age = 0;
      m_started = 1'b0;
      m_data = '0;
      m_ovf = 1'b0;
      m_tmo = 1'b0;
    end else begin
      m_oset = wr_en && (mq.size() == DEPTH);
      m_push = wr_en && (mq.size() < DEPTH);
      m_launch = !m_busy_xfer && en && (mq.size() > 0) && !busy_tx;
      m_hit = 1'b0;
      if (!m_busy_xfer) begin
        if (m_launch) begin
          m_data = mq.pop_front();
          m_busy_xfer = 1'b1;
          m_age = 0;
          m_started = 1'b0;
        end
      end else if (m_age == 0) begin
        m_age = 1;
      end else if (!m_started) begin
        if (busy_tx) m_started = 1'b1;
        else if (m_age == TMO) begin
          m_hit = 1'b1;
          m_busy_xfer = 1'b0;
        end else m_age++;
      end else if (!busy_tx) begin
        m_busy_xfer = 1'b0;
      end
      if (m_push) mq.push_back(wr_data);
      m_ovf = m_oset ? 1'b1 : (clr_err ? 1'b0 : m_ovf);
      m_tmo = m_hit ? 1'b1 : (clr_err ? 1'b0 : m_tmo);
    end
  end

  // every-cycle comparison against the model; also logs strobes
  logic [7:0] slog[$];
  always @(posedge clk) begin
    #2;
    if (rstn) begin
      bit e_full, e_empty, e_valid;
      e_full = (mq.size() == DEPTH);
      e_empty = (mq.size() == 0);
      e_valid = m_busy_xfer && (m_age == 0);
      checks++;
      if (full !== e_full || empty !== e_empty ||
          valid_tx !== e_valid || data !== m_data ||
          ovf !== m_ovf || tmo_err !== m_tmo) begin
        errs++;
        $display("FAIL model t=%0t got f%b e%b v%b d%h o%b t%b want f%b e%b v%b d%h o%b t%b",
                 $time, full, empty, valid_tx, data, ovf, tmo_err,
                 e_full, e_empty, e_valid, m_data, m_ovf, m_tmo);
      end
`ifdef UART_TX_BUFFER_LEVEL_EN
      checks++;
      if (level !== (AW+1)'(mq.size()) ||
          almost_full !== (mq.size() >= DEPTH - 2)) begin
        errs++;
        $display("FAIL level got %0d/%b want %0d", level,
                 almost_full, mq.size());
      end
`endif
      if (valid_tx) begin
        slog.push_back(data);
        checks++;
        if (busy_tx !== 1'b0) begin
          errs++;
          $display("FAIL strobe_busy got busy=%b want 0", busy_tx);
        end
      end
    end
  end

  task automatic chk(input string n, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got %h want %h", n, got, exp);
    end
  endtask

  task automatic push_one(input logic [7:0] b);
    @(negedge clk);
    wr_data = b;
    wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_strobes(input int n, input int budget);
    int k;
    k = 0;
    while (slog.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (slog.size() < n) begin
      errs++;
      $display("FAIL strobe_wait got %0d want %0d", slog.size(), n);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    repeat (3) @(negedge clk);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_valid", 32'(valid_tx), 0);
    chk("rst_data", 32'(data), 0);
    chk("rst_err", {ovf, tmo_err}, 0);
    rstn = 1'b1;
    en = 1'b1;
    rsp_on = 1'b1;

    // single byte, no bypass
    @(negedge clk);
    wr_data = 8'hA5;
    wr_en = 1'b1;
    @(posedge clk); #1;
    chk("t1_nonempty", 32'(empty), 0);
    chk("t1_novalid", 32'(valid_tx), 0);
    @(negedge clk);
    wr_en = 1'b0;
    @(posedge clk); #1;
    chk("t1_valid", 32'(valid_tx), 1);
    chk("t1_data", 32'(data), 32'hA5);
    chk("t1_empty", 32'(empty), 1);
    @(posedge clk); #1;
    chk("t1_pulse", 32'(valid_tx), 0);
    repeat (30) @(negedge clk);

    // three back-to-back bytes
    slog.delete();
    @(negedge clk);
    wr_en = 1'b1;
    wr_data = 8'h11;
    @(negedge clk);
    wr_data = 8'h22;
    @(negedge clk);
    wr_data = 8'h33;
    @(negedge clk);
    wr_en = 1'b0;
    wait_strobes(3, 300);
    chk("t2_order", {slog[0], slog[1], slog[2]}, 24'h112233);
    repeat (30) @(negedge clk);

    // fill past full with launches held
    en = 1'b0;
    slog.delete();
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      wr_data = 8'h40 + 8'(i);
      wr_en = 1'b1;
      @(posedge clk); #1;
      if (i == 14) chk("t3_notfull", 32'(full), 0);
      if (i == 15) chk("t3_full", 32'(full), 1);
      if (i == 15) chk("t3_noovf", 32'(ovf), 0);
      if (i == 16) chk("t3_ovf", 32'(ovf), 1);
    end
    @(negedge clk);
    wr_en = 1'b0;
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    chk("t3_ovf_clr", 32'(ovf), 0);
    chk("t3_held", slog.size(), 0);
    en = 1'b1;
    wait_strobes(16, 16 * 30 + 50);
    for (int i = 0; i < 16; i++)
      if (i < slog.size())
        chk("t3_order", 32'(slog[i]), 32'(8'h40 + 8'(i)));
    repeat (30) @(negedge clk);
    chk("t3_empty", 32'(empty), 1);

    // start timeout with busy held low
    rsp_on = 1'b0;
    en = 1'b0;
    push_one(8'h77);
    push_one(8'h88);
    repeat (3) @(negedge clk);
    slog.delete();
    en = 1'b1;
    t = 0;
    while (!valid_tx && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    chk("t4_launch", 32'(data), 32'h77);
    t = 0;
    while (!tmo_err && t < TMO + 10) begin
      @(posedge clk); #1;
      t++;
    end
    chk("t4_tmo_delay", t, TMO + 1);
    @(posedge clk); #1;
    chk("t4_next", {valid_tx, data}, {1'b1, 8'h88});
    rsp_on = 1'b1;
    repeat (40) @(negedge clk);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    chk("t4_clr", 32'(tmo_err), 0);

    // simultaneous push and launch at count 4
    en = 1'b0;
    for (int i = 1; i <= 4; i++) push_one(8'(i));
    @(negedge clk);
    en = 1'b1;
    wr_en = 1'b1;
    wr_data = 8'h05;
    @(posedge clk); #1;
    chk("t5_launch", {valid_tx, data}, {1'b1, 8'h01});
    chk("t5_flags", {full, empty}, 2'b00);
`ifdef UART_TX_BUFFER_LEVEL_EN
    chk("t5_level", 32'(level), 4);
`endif
    @(negedge clk);
    wr_en = 1'b0;
    repeat (5 * 30) @(negedge clk);
    chk("t5_drained", 32'(empty), 1);

    // reset during WAIT_END with 5 bytes queued
    en = 1'b0;
    for (int i = 0; i < 6; i++) push_one(8'hC0 + 8'(i));
    slog.delete();
    en = 1'b1;
    wait_strobes(1, 20);
    t = 0;
    while (!busy_tx && t < 10) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    rstn = 1'b0;
    rsp_on = 1'b0;
    #1;
    chk("t6_rst", {empty, full, valid_tx, data, ovf, tmo_err},
        {1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0});
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    rsp_on = 1'b1;
    repeat (10) @(negedge clk);
    chk("t6_no_strobe", slog.size(), 1);
    push_one(8'h9A);
    wait_strobes(2, 20);
    if (slog.size() >= 2) chk("t6_new", 32'(slog[1]), 32'h9A);
    repeat (30) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
